// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: region decode, byte-lane selects, wait states,
// DTACK generation, BERR watchdog and a boot-time ROM overlay at region 0.
module bus_cycle_ctrl #(
    parameter int ROM_WS       = 2,
    parameter int RAM_WS       = 0,
    parameter int BERR_TIMEOUT = 64,
    parameter int BOOT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       as_n,
    input  logic       uds_n,
    input  logic       lds_n,
    input  logic [3:0] addr_hi,
    input  logic       duart_dtack_n,
    output logic       rom_evn_cs_n,
    output logic       rom_odd_cs_n,
    output logic       ram_evn_cs_n,
    output logic       ram_odd_cs_n,
    output logic       duart_cs_n,
    output logic       dtack_n,
    output logic       berr_n
);

    localparam int WS_MAX = (ROM_WS > RAM_WS) ? ROM_WS : RAM_WS;
    localparam int WCW    = (WS_MAX > 0) ? $clog2(WS_MAX + 1) : 1;
    localparam int WDW    = $clog2(BERR_TIMEOUT);
    localparam int BCW    = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;
    typedef enum logic [1:0] {K_NONE, K_ROM, K_RAM, K_DUART} kind_t;

    state_t         state_q, state_d;
    kind_t          kind_q, kind_d;
    kind_t          region_kind;
    logic           uds_q, uds_d;
    logic           lds_q, lds_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [BCW-1:0] boot_cnt_q, boot_cnt_d;

    logic rom_evn_q, rom_evn_d;
    logic rom_odd_q, rom_odd_d;
    logic ram_evn_q, ram_evn_d;
    logic ram_odd_q, ram_odd_d;
    logic duart_q, duart_d;
    logic dtack_q, dtack_d;
    logic berr_q, berr_d;

    logic boot_active;
    logic is_mem;

    assign boot_active = (boot_cnt_q < BCW'(BOOT_CYCLES));
    assign is_mem      = (kind_q == K_ROM) || (kind_q == K_RAM);

    always_comb begin
        region_kind = K_NONE;
        case (addr_hi)
            4'h0:    region_kind = boot_active ? K_ROM : K_RAM;
            4'h1,
            4'h2,
            4'h3,
            4'h4,
            4'h5,
            4'h6,
            4'h7:    region_kind = K_RAM;
            4'hE:    region_kind = K_ROM;
            4'hF:    region_kind = K_DUART;
            default: region_kind = K_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= K_NONE;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            wait_cnt_q <= '0;
            wdog_q     <= '0;
            boot_cnt_q <= '0;
            rom_evn_q  <= 1'b1;
            rom_odd_q  <= 1'b1;
            ram_evn_q  <= 1'b1;
            ram_odd_q  <= 1'b1;
            duart_q    <= 1'b1;
            dtack_q    <= 1'b1;
            berr_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            uds_q      <= uds_d;
            lds_q      <= lds_d;
            wait_cnt_q <= wait_cnt_d;
            wdog_q     <= wdog_d;
            boot_cnt_q <= boot_cnt_d;
            rom_evn_q  <= rom_evn_d;
            rom_odd_q  <= rom_odd_d;
            ram_evn_q  <= ram_evn_d;
            ram_odd_q  <= ram_odd_d;
            duart_q    <= duart_d;
            dtack_q    <= dtack_d;
            berr_q     <= berr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        uds_d      = uds_q;
        lds_d      = lds_q;
        wait_cnt_d = wait_cnt_q;
        wdog_d     = wdog_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!as_n && (!uds_n || !lds_n)) begin
                    state_d = S_WAIT;
                    kind_d  = region_kind;
                    uds_d   = !uds_n;
                    lds_d   = !lds_n;
                    wdog_d  = '0;
                    case (region_kind)
                        K_ROM:   wait_cnt_d = WCW'(ROM_WS);
                        K_RAM:   wait_cnt_d = WCW'(RAM_WS);
                        default: wait_cnt_d = '0;
                    endcase
                end
            end
            S_WAIT: begin
                // Priority: abort, then ack sources, then the watchdog.
                if (as_n) begin
                    state_d = S_IDLE;
                end else if (is_mem) begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - WCW'(1);
                    end else begin
                        state_d = S_ACK;
                    end
                end else if (kind_q == K_DUART && !duart_dtack_n) begin
                    state_d = S_ACK;
                end else if (wdog_q == WDW'(BERR_TIMEOUT - 1)) begin
                    state_d = S_BERR;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_ACK: begin
                if (as_n) begin
                    state_d = S_IDLE;
                    if (boot_active) begin
                        boot_cnt_d = boot_cnt_q + BCW'(1);
                    end
                end
            end
            S_BERR: begin
                if (as_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are a pure function of the next state so they land in flops.
    always_comb begin
        logic sel;
        sel       = (state_d != S_IDLE);
        rom_evn_d = !(sel && kind_d == K_ROM && uds_d);
        rom_odd_d = !(sel && kind_d == K_ROM && lds_d);
        ram_evn_d = !(sel && kind_d == K_RAM && uds_d);
        ram_odd_d = !(sel && kind_d == K_RAM && lds_d);
        duart_d   = !(sel && kind_d == K_DUART);
        dtack_d   = !(state_d == S_ACK);
        berr_d    = !(state_d == S_BERR);
    end

    assign rom_evn_cs_n = rom_evn_q;
    assign rom_odd_cs_n = rom_odd_q;
    assign ram_evn_cs_n = ram_evn_q;
    assign ram_odd_cs_n = ram_odd_q;
    assign duart_cs_n   = duart_q;
    assign dtack_n      = dtack_q;
    assign berr_n       = berr_q;

endmodule
